rmii_rx_ctrl: RTL and testbench
===============================

// Module: rmii_rx_ctrl
// PURPOSE
//  Receive-side sequencer for the RMII dibit stream. Strips preamble and SFD,
//  aligns and gates a dibits_to_bytes converter on the SFD boundary, and ends
//  the frame when CRS_DV drops. Flags alignment and length errors.
//  Sits between the RMII PHY pins (already synchronised) and the frame buffer.
// PARAMETERS
//  MIN_PRE_DIBITS   8     consecutive 2'b01 dibits required before SFD is accepted
//  MAX_FRAME_BYTES  1522  byte count above which err_long is raised
//  BYTE_LEN / BYTE_LEN_LOG2 come from params.vh (8 / 3); not overridable here
// PORTS
//  clk        in   1         system clock, one RMII dibit per cycle
//  reset      in   1         synchronous, active-high
//  crsdv      in   1         RMII CRS_DV, already synchronised
//  rxd        in   2         RMII RXD[1:0], LSB dibit first
//  out        out  BYTE_LEN  received byte, valid when outclk=1
//  outclk     out  1         one-cycle strobe per byte
//  done_out   out  1         one-cycle strobe after the last byte of a good or bad frame
//  busy       out  1         high from SFD until done_out
//  err_align  out  1         with done_out: frame ended on a non-byte boundary
//  err_long   out  1         with done_out: byte count > MAX_FRAME_BYTES
//  byte_cnt   out  11        bytes in the current/last frame; holds until the next SFD
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters 0; converter held in reset.
//  FSM states and transitions:
//   IDLE:  crsdv&&rxd==01 -> PRE, pre_cnt=1.
//   PRE:   !crsdv -> IDLE.
//          rxd==01 -> pre_cnt++ (saturating at MIN_PRE_DIBITS).
//          rxd==11 && pre_cnt>=MIN_PRE_DIBITS -> DATA; this SFD cycle pulses the
//            converter reset, so the next dibit is bits[1:0] of byte 0.
//          any other dibit, or 11 early -> DROP.
//   DATA:  crsdv -> converter inclk=1, in=rxd, dib_cnt++ (2-bit, wraps);
//            byte_cnt++ (saturate 2047) when dib_cnt wraps 3->0.
//          !crsdv -> END; err_align_r = (dib_cnt!=0); err_long_r = byte_cnt>MAX.
//   END:   one cycle; converter done_in=1 -> IDLE.
//   DROP:  !crsdv -> IDLE; no outputs asserted, byte_cnt unchanged.
//  Latency: outclk rises 1 cycle after the cycle presenting the 4th dibit of a byte.
//   done_out rises 1 cycle after END, i.e. after the final outclk.
//   err_* are valid only while done_out=1; 0 otherwise.
//  busy: set on the SFD cycle; cleared on the done_out cycle.
//  Partial trailing dibits (err_align) are discarded; no partial byte is emitted.
//  crsdv and an SFD in the same cycle as END: ignored, IDLE re-arms next cycle
//   (a back-to-back frame needs a >=1 cycle gap).
//  Reset mid-frame: immediate return to IDLE, no done_out, converter cleared.
//  byte_cnt: cleared on SFD; not cleared by DROP.
// STRUCTURE
//  params.vh: BYTE_LEN, BYTE_LEN_LOG2, state localparams RX_IDLE/PRE/DATA/END/DROP.
//  Sub-module: one dibits_to_bytes instance. Its reset = reset | sfd_pulse;
//   inclk/in/done_in are driven by the FSM; out/outclk/done_out pass through.
//  The FSM and the counters are in this file.
// TESTING
//  1. 28x01, 11, then bytes 0x55,0xD5,0xA3 LSB-dibit-first, crsdv low ->
//     three outclk with out=55,D5,A3; done_out 1 cycle after; err_*=0; byte_cnt=3.
//  2. Only 4x01 then 11 (MIN=8) -> DROP; no outclk, no done_out, busy stays 0.
//  3. SFD, then 9 dibits, crsdv low -> 2 bytes out, done_out with err_align=1.
//  4. 1523-byte payload -> done_out with err_long=1; byte_cnt=1523.
//  5. reset asserted after byte 2 of 5 -> no further outclk/done_out; a new
//     frame decodes correctly.
//  6. Two frames with a 1-cycle crsdv gap -> both decoded; two done_out pulses.

Source files
------------

// File: rtl/rmii_rx_ctrl_pkg.sv
// Shared definitions for the RMII receive sequencer.
//   BYTE_LEN / BYTE_LEN_LOG2 : byte geometry used by the dibit converter
//   BYTE_CNT_W               : width of the per-frame byte counter
//   rx_state_t               : sequencer state encoding
//   DIBIT_PRE / DIBIT_SFD    : line symbols of interest during the preamble
package rmii_rx_ctrl_pkg;

    localparam int BYTE_LEN      = 8;
    localparam int BYTE_LEN_LOG2 = 3;
    localparam int BYTE_CNT_W    = 11;

    localparam logic [1:0] DIBIT_PRE = 2'b01;
    localparam logic [1:0] DIBIT_SFD = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PRE,
        RX_DATA,
        RX_END,
        RX_DROP
    } rx_state_t;

endpackage

// File: rtl/rmii_rx_ctrl_dibits_to_bytes.sv
// Dibit-to-byte assembler, LSB dibit first.
//   clk, reset : clock and synchronous active-high reset
//   inclk      : a dibit is presented on 'in' this cycle
//   in         : dibit value
//   done_in    : end of frame; any partial byte is discarded
//   out        : assembled byte, valid while outclk=1
//   outclk     : one-cycle strobe, one cycle after the 4th dibit of a byte
//   done_out   : done_in delayed by one cycle
module rmii_rx_ctrl_dibits_to_bytes
    import rmii_rx_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inclk,
    input  logic [1:0]          in,
    input  logic                done_in,
    output logic [BYTE_LEN-1:0] out,
    output logic                outclk,
    output logic                done_out
);

    localparam logic [BYTE_LEN_LOG2-2:0] LAST_DIBIT = '1;

    logic [BYTE_LEN-3:0]      sr_p0;
    logic [BYTE_LEN_LOG2-2:0] dib_cnt_p0;

    // Stage p0: shift register collects the first three dibits of a byte.
    // Stage p1: byte register and strobe, loaded with the fourth dibit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_p0      <= '0;
            dib_cnt_p0 <= '0;
            out        <= '0;
            outclk     <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            outclk   <= 1'b0;
            done_out <= done_in;
            if (done_in) begin
                dib_cnt_p0 <= '0;
            end else if (inclk) begin
                // New dibits enter at the top so the first one ends up in bits [1:0].
                sr_p0      <= {in, sr_p0[BYTE_LEN-3:2]};
                dib_cnt_p0 <= dib_cnt_p0 + 1'b1;
                if (dib_cnt_p0 == LAST_DIBIT) begin
                    out    <= {in, sr_p0};
                    outclk <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rmii_rx_ctrl.sv
// RMII receive sequencer: strips preamble/SFD, feeds payload dibits to the
// byte assembler from the SFD boundary on, ends the frame when CRS_DV drops
// and reports alignment / over-length errors alongside done_out.
//   clk, reset : clock (one dibit per cycle), synchronous active-high reset
//   crsdv, rxd : synchronised RMII CRS_DV and RXD[1:0]
//   out/outclk : received byte and its one-cycle strobe
//   done_out   : one-cycle strobe after the last byte of a frame
//   busy       : high from the SFD cycle until done_out
//   err_align  : with done_out, frame ended mid-byte
//   err_long   : with done_out, more than MAX_FRAME_BYTES bytes
//   byte_cnt   : bytes in the current/last frame, cleared on SFD
module rmii_rx_ctrl
    import rmii_rx_ctrl_pkg::*;
#(
    parameter int MIN_PRE_DIBITS  = 8,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  crsdv,
    input  logic [1:0]            rxd,
    output logic [BYTE_LEN-1:0]   out,
    output logic                  outclk,
    output logic                  done_out,
    output logic                  busy,
    output logic                  err_align,
    output logic                  err_long,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    localparam int PRE_W = $clog2(MIN_PRE_DIBITS + 1);

    rx_state_t       state, state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [1:0]       dib_cnt;
    logic             err_align_r, err_long_r;
    logic             sfd_pulse, d2b_inclk, d2b_done_in, d2b_reset, d2b_done_out;

    function automatic logic [PRE_W-1:0] sat_pre_inc(input logic [PRE_W-1:0] v);
        if (v >= PRE_W'(MIN_PRE_DIBITS)) return PRE_W'(MIN_PRE_DIBITS);
        return v + 1'b1;
    endfunction

    function automatic logic [BYTE_CNT_W-1:0] sat_byte_inc(input logic [BYTE_CNT_W-1:0] v);
        if (v == '1) return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        state_nxt   = state;
        sfd_pulse   = 1'b0;
        d2b_inclk   = 1'b0;
        d2b_done_in = 1'b0;
        case (state)
            RX_IDLE: if (crsdv && rxd == DIBIT_PRE) state_nxt = RX_PRE;
            RX_PRE: begin
                if (!crsdv) begin
                    state_nxt = RX_IDLE;
                end else if (rxd == DIBIT_PRE) begin
                    state_nxt = RX_PRE;
                end else if (rxd == DIBIT_SFD && pre_cnt >= PRE_W'(MIN_PRE_DIBITS)) begin
                    state_nxt = RX_DATA;
                    sfd_pulse = 1'b1;
                end else begin
                    state_nxt = RX_DROP;
                end
            end
            RX_DATA: begin
                if (crsdv) d2b_inclk = 1'b1;
                else       state_nxt = RX_END;
            end
            RX_END: begin
                d2b_done_in = 1'b1;
                state_nxt   = RX_IDLE;
            end
            RX_DROP: if (!crsdv) state_nxt = RX_IDLE;
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX_IDLE;
            pre_cnt     <= '0;
            dib_cnt     <= '0;
            byte_cnt    <= '0;
            err_align_r <= 1'b0;
            err_long_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RX_IDLE && state_nxt == RX_PRE)
                pre_cnt <= PRE_W'(1);
            else if (state == RX_PRE && crsdv && rxd == DIBIT_PRE)
                pre_cnt <= sat_pre_inc(pre_cnt);
            if (sfd_pulse) begin
                byte_cnt <= '0;
                dib_cnt  <= '0;
            end else if (d2b_inclk) begin
                dib_cnt <= dib_cnt + 2'd1;
                if (dib_cnt == 2'd3) byte_cnt <= sat_byte_inc(byte_cnt);
            end
            // Errors are latched as CRS_DV drops and exposed only with done_out.
            if (state == RX_DATA && !crsdv) begin
                err_align_r <= (dib_cnt != 2'd0);
                err_long_r  <= (int'(byte_cnt) > MAX_FRAME_BYTES);
            end
        end
    end

    // The SFD cycle clears the assembler so the next dibit is bits [1:0] of byte 0.
    assign d2b_reset = reset | sfd_pulse;

    rmii_rx_ctrl_dibits_to_bytes u_d2b (
        .clk      (clk),
        .reset    (d2b_reset),
        .inclk    (d2b_inclk),
        .in       (rxd),
        .done_in  (d2b_done_in),
        .out      (out),
        .outclk   (outclk),
        .done_out (d2b_done_out)
    );

    assign done_out  = d2b_done_out;
    assign err_align = d2b_done_out & err_align_r;
    assign err_long  = d2b_done_out & err_long_r;
    assign busy      = sfd_pulse | (state == RX_DATA) | (state == RX_END);

endmodule

// File: tb/tb_rmii_rx_ctrl.sv
module tb_rmii_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic [7:0]  out;
    logic        outclk, done_out, busy, err_align, err_long;
    logic [10:0] byte_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    // monitor state
    int         cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         n_done, done_cyc, last_oc_cyc, n_stray;
    logic       cap_align, cap_long, busy_seen;

    rmii_rx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .crsdv     (crsdv),
        .rxd       (rxd),
        .out       (out),
        .outclk    (outclk),
        .done_out  (done_out),
        .busy      (busy),
        .err_align (err_align),
        .err_long  (err_long),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outclk) begin
            rx_q.push_back(out);
            last_oc_cyc = cyc;
        end
        if (done_out) begin
            n_done++;
            done_cyc  = cyc;
            cap_align = err_align;
            cap_long  = err_long;
        end
        if (!done_out && (err_align || err_long)) n_stray++;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        rx_q.delete();
        n_done = 0; done_cyc = 0; last_oc_cyc = 0; n_stray = 0;
        cap_align = 1'bx; cap_long = 1'bx; busy_seen = 1'b0;
    endtask

    task automatic dib(input logic c, input logic [1:0] r);
        @(posedge clk);
        #1;
        crsdv = c;
        rxd   = r;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) dib(1'b1, b[2*k +: 2]);
    endtask

    // preamble, SFD, tx_q payload, ntail stray dibits, then CRS_DV low for one cycle
    task automatic send_frame(input int npre, input int ntail);
        for (int k = 0; k < npre; k++) dib(1'b1, 2'b01);
        dib(1'b1, 2'b11);
        for (int k = 0; k < tx_q.size(); k++) send_byte(tx_q[k]);
        for (int k = 0; k < ntail; k++) dib(1'b1, 2'b10);
        dib(1'b0, 2'b00);
    endtask

    task automatic idle(input int n);
        repeat (n) dib(1'b0, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        crsdv = 1'b1;
        rxd   = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({out, outclk, done_out, busy, err_align, err_long} !== 13'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h expected 0", {out, outclk, done_out, busy, err_align, err_long});
        end
        n_vec++;
        if (byte_cnt !== 11'd0) begin
            n_miss++;
            $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt);
        end
        crsdv = 1'b0;
        rxd   = 2'b00;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        clr_mon();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b[3] = '{8'h55, 8'hD5, 8'hA3};
        clr_mon();
        tx_q = '{8'h55, 8'hD5, 8'hA3};
        send_frame(28, 0);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 3) begin
            n_miss++;
            $display("FAIL basic_count: got %0d expected 3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
                n_miss++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_b[i]);
            end
        end
        n_vec++;
        if (n_done !== 1 || cap_align !== 1'b0 || cap_long !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_done: got done=%0d align=%b long=%b expected 1/0/0", n_done, cap_align, cap_long);
        end
        n_vec++;
        if (done_cyc - last_oc_cyc !== 2) begin
            n_miss++;
            $display("FAIL basic_done_latency: got %0d expected 2", done_cyc - last_oc_cyc);
        end
        n_vec++;
        if (byte_cnt !== 11'd3) begin
            n_miss++;
            $display("FAIL basic_byte_cnt: got %0d expected 3", byte_cnt);
        end
        n_vec++;
        if (busy_seen !== 1'b1 || busy !== 1'b0 || n_stray !== 0) begin
            n_miss++;
            $display("FAIL basic_busy: got seen=%b now=%b stray=%0d expected 1/0/0", busy_seen, busy, n_stray);
        end
    endtask

    task automatic test_short_preamble();
        clr_mon();
        for (int k = 0; k < 4; k++) dib(1'b1, 2'b01);
        dib(1'b1, 2'b11);
        send_byte(8'h55);
        send_byte(8'hD5);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 0 || n_done !== 0 || busy_seen !== 1'b0) begin
            n_miss++;
            $display("FAIL short_pre: got bytes=%0d done=%0d busy=%b expected 0/0/0", rx_q.size(), n_done, busy_seen);
        end
        n_vec++;
        if (byte_cnt !== 11'd3) begin
            n_miss++;
            $display("FAIL short_pre_byte_cnt_hold: got %0d expected 3", byte_cnt);
        end
    endtask

    task automatic test_pre_boundary();
        clr_mon();
        tx_q = '{8'h3C};
        send_frame(7, 0);
        idle(4);
        n_vec++;
        if (rx_q.size() !== 0 || n_done !== 0) begin
            n_miss++;
            $display("FAIL pre7_drop: got bytes=%0d done=%0d expected 0/0", rx_q.size(), n_done);
        end
        clr_mon();
        send_frame(8, 0);
        idle(4);
        n_vec++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C || n_done !== 1) begin
            n_miss++;
            $display("FAIL pre8_accept: got bytes=%0d first=%h done=%0d expected 1/3c/1",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, n_done);
        end
    endtask

    task automatic test_align();
        clr_mon();
        tx_q = '{8'h12, 8'h34};
        send_frame(10, 1);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'h12 || rx_q[1] !== 8'h34) begin
            n_miss++;
            $display("FAIL align_bytes: got n=%0d expected 2 bytes 12 34", rx_q.size());
        end
        n_vec++;
        if (n_done !== 1 || cap_align !== 1'b1 || cap_long !== 1'b0 || n_stray !== 0) begin
            n_miss++;
            $display("FAIL align_err: got done=%0d align=%b long=%b stray=%0d expected 1/1/0/0",
                     n_done, cap_align, cap_long, n_stray);
        end
        n_vec++;
        if (byte_cnt !== 11'd2) begin
            n_miss++;
            $display("FAIL align_byte_cnt: got %0d expected 2", byte_cnt);
        end
    endtask

    task automatic test_long(input int nbytes, input logic exp_long);
        clr_mon();
        tx_q.delete();
        for (int i = 0; i < nbytes; i++) tx_q.push_back(i[7:0]);
        send_frame(12, 0);
        idle(6);
        n_vec++;
        if (rx_q.size() !== nbytes || rx_q[nbytes-1] !== 8'(nbytes - 1)) begin
            n_miss++;
            $display("FAIL long%0d_bytes: got n=%0d expected %0d", nbytes, rx_q.size(), nbytes);
        end
        n_vec++;
        if (n_done !== 1 || cap_long !== exp_long || cap_align !== 1'b0) begin
            n_miss++;
            $display("FAIL long%0d_err: got done=%0d long=%b align=%b expected 1/%b/0",
                     nbytes, n_done, cap_long, cap_align, exp_long);
        end
        n_vec++;
        if (byte_cnt !== 11'(nbytes)) begin
            n_miss++;
            $display("FAIL long%0d_byte_cnt: got %0d expected %0d", nbytes, byte_cnt, nbytes);
        end
    endtask

    task automatic test_reset_mid_frame();
        clr_mon();
        for (int k = 0; k < 10; k++) dib(1'b1, 2'b01);
        dib(1'b1, 2'b11);
        send_byte(8'hA1);
        send_byte(8'hB2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        send_byte(8'hC3);
        send_byte(8'hD4);
        send_byte(8'hE5);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'hA1 || rx_q[1] !== 8'hB2) begin
            n_miss++;
            $display("FAIL midreset_bytes: got n=%0d expected 2 bytes a1 b2", rx_q.size());
        end
        n_vec++;
        if (n_done !== 0 || byte_cnt !== 11'd0) begin
            n_miss++;
            $display("FAIL midreset_done: got done=%0d byte_cnt=%0d expected 0/0", n_done, byte_cnt);
        end
        clr_mon();
        tx_q = '{8'hC3};
        send_frame(9, 0);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3 || n_done !== 1 || byte_cnt !== 11'd1) begin
            n_miss++;
            $display("FAIL midreset_recover: got n=%0d done=%0d byte_cnt=%0d expected 1 byte c3/1/1",
                     rx_q.size(), n_done, byte_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clr_mon();
        tx_q = '{8'h5A};
        send_frame(12, 0);
        tx_q = '{8'h9C};
        send_frame(12, 0);
        idle(6);
        n_vec++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h9C) begin
            n_miss++;
            $display("FAIL b2b_bytes: got n=%0d expected 2 bytes 5a 9c", rx_q.size());
        end
        n_vec++;
        if (n_done !== 2 || byte_cnt !== 11'd1 || n_stray !== 0) begin
            n_miss++;
            $display("FAIL b2b_done: got done=%0d byte_cnt=%0d stray=%0d expected 2/1/0",
                     n_done, byte_cnt, n_stray);
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_basic();
        test_short_preamble();
        test_pre_boundary();
        test_align();
        test_long(1523, 1'b1);
        test_long(1522, 1'b0);
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
